// File: rtl/alu_chk_pkg.sv
// Shared types and rule indices for the start/done ALU handshake checker.
package alu_chk_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam int unsigned NUM_RULES           = 6;
  localparam int unsigned RULE_DONE_NO_START  = 0;
  localparam int unsigned RULE_DONE_AFTER_NOP = 1;
  localparam int unsigned RULE_DONE_WIDTH     = 2;
  localparam int unsigned RULE_OPERAND_CHANGE = 3;
  localparam int unsigned RULE_TIMEOUT        = 4;
  localparam int unsigned RULE_ABANDON        = 5;

endpackage

// File: rtl/alu_chk_sat_counter.sv
// Saturating up-counter; a clear and an increment in the same cycle yields 1.
module alu_chk_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_protocol_checker.sv
// Passive checker for the start/done ALU handshake: per-rule error strobes,
// sticky flags, and latency/transaction statistics.
module alu_protocol_checker
  import alu_chk_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned NOP_OP  = 0,
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         clr_stats,
  input  logic                         start,
  input  logic [OP_W-1:0]              op,
  input  logic [DATA_W-1:0]            A,
  input  logic [DATA_W-1:0]            B,
  input  logic                         done,
  input  logic [2*DATA_W-1:0]          result,
  output logic [NUM_RULES-1:0]         err_pulse,
  output logic [NUM_RULES-1:0]         err_sticky,
  output logic [CNT_W-1:0]             err_count,
  output logic [CNT_W-1:0]             txn_count,
  output logic [$clog2(MAX_LAT+1)-1:0] lat_max,
  output logic [2*DATA_W-1:0]          last_result,
  output logic                         busy
);

  localparam int unsigned      LAT_W     = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(MAX_LAT);

  state_e                state, state_nxt;
  logic [OP_W-1:0]       cap_op;
  logic [DATA_W-1:0]     cap_a, cap_b;
  logic [LAT_W-1:0]      lat, done_lat;
  logic                  nop_d, done_d, to_fired;
  logic                  is_nop, launch, complete;
  logic [NUM_RULES-1:0]  det, det_en;

  assign is_nop = (op == OP_W'(NOP_OP));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !is_nop && !done) state_nxt = S_BUSY;
      S_BUSY:  if (done || !start)            state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == S_BUSY);
    launch   = (state == S_IDLE) && start && !is_nop && !done;
    complete = ((state == S_IDLE) && start && !is_nop && done) ||
               ((state == S_BUSY) && done);
    done_lat = (state == S_BUSY) ? lat : '0;

    det = '0;
    det[RULE_DONE_NO_START]  = done && !start;
    det[RULE_DONE_AFTER_NOP] = done && nop_d;
    det[RULE_DONE_WIDTH]     = done && done_d;
    det[RULE_OPERAND_CHANGE] = (state == S_BUSY) && start &&
                               ({op, A, B} != {cap_op, cap_a, cap_b});
    // lat saturates at the limit, so to_fired keeps the timeout to one strobe
    det[RULE_TIMEOUT]        = (state == S_BUSY) && !done &&
                               (lat == LAT_LIMIT) && !to_fired;
    det[RULE_ABANDON]        = (state == S_BUSY) && !start && !done;

    det_en = enable ? det : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_op      <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      lat         <= '0;
      nop_d       <= 1'b0;
      done_d      <= 1'b0;
      to_fired    <= 1'b0;
      err_pulse   <= '0;
      err_sticky  <= '0;
      lat_max     <= '0;
      last_result <= '0;
    end else begin
      nop_d  <= (state == S_IDLE) && start && is_nop;
      done_d <= done;

      if (launch) begin
        cap_op   <= op;
        cap_a    <= A;
        cap_b    <= B;
        lat      <= LAT_W'(1);
        to_fired <= 1'b0;
      end else if ((state == S_BUSY) && !done) begin
        if (lat != LAT_LIMIT)   lat      <= lat + LAT_W'(1);
        if (det[RULE_TIMEOUT])  to_fired <= 1'b1;
      end

      err_pulse  <= det_en;
      err_sticky <= (clr_stats ? '0 : err_sticky) | det_en;

      if (complete) last_result <= result;

      if (clr_stats)                          lat_max <= complete ? done_lat : '0;
      else if (complete && done_lat > lat_max) lat_max <= done_lat;
    end
  end

  alu_chk_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (|det_en),
    .clr     (clr_stats),
    .count   (err_count)
  );

  alu_chk_sat_counter #(.W(CNT_W)) u_txn_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (complete),
    .clr     (clr_stats),
    .count   (txn_count)
  );

endmodule

// File: tb/tb_alu_protocol_checker.sv
// Directed bench for alu_protocol_checker: a cycle-by-cycle vector table plus
// hand sequences for timeout/abandon, enable masking, clear, saturation and reset.
module tb_alu_protocol_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        clr_stats;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  a_i, b_i;
  logic        done;
  logic [15:0] result;
  logic [5:0]  err_pulse, err_sticky;
  logic [3:0]  err_count, txn_count, lat_max;
  logic [15:0] last_result;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_protocol_checker #(
    .DATA_W  (8),
    .OP_W    (3),
    .NOP_OP  (0),
    .MAX_LAT (8),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clr_stats   (clr_stats),
    .start       (start),
    .op          (op),
    .A           (a_i),
    .B           (b_i),
    .done        (done),
    .result      (result),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .err_count   (err_count),
    .txn_count   (txn_count),
    .lat_max     (lat_max),
    .last_result (last_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        dn;
    logic [15:0] res;
    logic [5:0]  e_pulse;
    logic        e_busy;
    logic [3:0]  e_txn;
    logic [3:0]  e_lat;
    logic [3:0]  e_err;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic d, input logic [15:0] r);
    start  = s;
    op     = o;
    a_i    = a;
    b_i    = b;
    done   = d;
    result = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //           st op  a      b      dn res       pulse     busy txn lat err
    vt[0]  = '{1'b1, 3'd1, 8'h05, 8'h03, 1'b0, 16'h0000, 6'b000000, 1'b1, 4'd0, 4'd0, 4'd0};
    vt[1]  = '{1'b1, 3'd1, 8'h05, 8'h03, 1'b0, 16'h0000, 6'b000000, 1'b1, 4'd0, 4'd0, 4'd0};
    vt[2]  = '{1'b1, 3'd1, 8'h05, 8'h03, 1'b0, 16'h0000, 6'b000000, 1'b1, 4'd0, 4'd0, 4'd0};
    vt[3]  = '{1'b1, 3'd1, 8'h05, 8'h03, 1'b1, 16'h0008, 6'b000000, 1'b0, 4'd1, 4'd3, 4'd0};
    vt[4]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000, 6'b000000, 1'b0, 4'd1, 4'd3, 4'd0};
    vt[5]  = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000, 6'b000000, 1'b0, 4'd1, 4'd3, 4'd0};
    vt[6]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 16'h0000, 6'b000011, 1'b0, 4'd1, 4'd3, 4'd1};
    vt[7]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000, 6'b000000, 1'b0, 4'd1, 4'd3, 4'd1};
    vt[8]  = '{1'b1, 3'd2, 8'h07, 8'h01, 1'b0, 16'h0000, 6'b000000, 1'b1, 4'd1, 4'd3, 4'd1};
    vt[9]  = '{1'b1, 3'd2, 8'h07, 8'h01, 1'b1, 16'h0007, 6'b000000, 1'b0, 4'd2, 4'd3, 4'd1};
    vt[10] = '{1'b0, 3'd2, 8'h07, 8'h01, 1'b1, 16'h0007, 6'b000101, 1'b0, 4'd2, 4'd3, 4'd2};
    vt[11] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000, 6'b000000, 1'b0, 4'd2, 4'd3, 4'd2};
    vt[12] = '{1'b1, 3'd3, 8'h02, 8'h08, 1'b1, 16'h0010, 6'b000000, 1'b0, 4'd3, 4'd3, 4'd2};
    vt[13] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000, 6'b000000, 1'b0, 4'd3, 4'd3, 4'd2};

    reset_n = 1'b0; enable = 1'b1; clr_stats = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000);
    #12;
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_pulse",   32'(err_pulse),   32'd0);
    chk("rst_sticky",  32'(err_sticky),  32'd0);
    chk("rst_errcnt",  32'(err_count),   32'd0);
    chk("rst_txn",     32'(txn_count),   32'd0);
    chk("rst_latmax",  32'(lat_max),     32'd0);
    chk("rst_lastres", 32'(last_result), 32'd0);
    reset_n = 1'b1;

    // Legal ADD, NOP-then-done, double-width done, zero-latency completion
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].st, vt[i].op, vt[i].a, vt[i].b, vt[i].dn, vt[i].res);
      tick();
      chk($sformatf("v%0d_pulse", i),  32'(err_pulse), 32'(vt[i].e_pulse));
      chk($sformatf("v%0d_busy", i),   32'(busy),      32'(vt[i].e_busy));
      chk($sformatf("v%0d_txn", i),    32'(txn_count), 32'(vt[i].e_txn));
      chk($sformatf("v%0d_latmax", i), 32'(lat_max),   32'(vt[i].e_lat));
      chk($sformatf("v%0d_errcnt", i), 32'(err_count), 32'(vt[i].e_err));
      if (i == 3) chk("add_lastres", 32'(last_result), 32'h0008);
    end
    chk("table_sticky",  32'(err_sticky),  32'b000111);
    chk("table_lastres", 32'(last_result), 32'h0010);

    // Operand change, single timeout strobe, then abandon
    drive(1'b1, 3'd1, 8'h05, 8'h03, 1'b0, 16'h0000);
    tick();
    chk("oc_launch_busy",  32'(busy),      32'd1);
    chk("oc_launch_pulse", 32'(err_pulse), 32'd0);
    drive(1'b1, 3'd1, 8'h06, 8'h03, 1'b0, 16'h0000);
    tick();
    chk("oc_pulse", 32'(err_pulse), 32'b001000);
    for (int k = 2; k <= 9; k++) begin
      drive(1'b1, 3'd1, 8'h05, 8'h03, 1'b0, 16'h0000);
      tick();
      chk($sformatf("to_pulse_e%0d", k), 32'(err_pulse), (k == 8) ? 32'b010000 : 32'd0);
    end
    drive(1'b0, 3'd1, 8'h05, 8'h03, 1'b0, 16'h0000);
    tick();
    chk("ab_pulse",  32'(err_pulse),  32'b100000);
    chk("ab_busy",   32'(busy),       32'd0);
    chk("ab_errcnt", 32'(err_count),  32'd5);
    chk("ab_sticky", 32'(err_sticky), 32'b111111);
    chk("ab_txn",    32'(txn_count),  32'd3);

    // Clear, enable masking, clear coinciding with a new error
    clr_stats = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000);
    tick();
    clr_stats = 1'b0;
    chk("clr_sticky", 32'(err_sticky), 32'd0);
    chk("clr_errcnt", 32'(err_count),  32'd0);
    chk("clr_txn",    32'(txn_count),  32'd0);
    chk("clr_latmax", 32'(lat_max),    32'd0);
    enable = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 16'h0000);
    tick();
    chk("dis_pulse",  32'(err_pulse),  32'd0);
    chk("dis_sticky", 32'(err_sticky), 32'd0);
    chk("dis_errcnt", 32'(err_count),  32'd0);
    enable = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000);
    tick();
    chk("en_quiet_pulse", 32'(err_pulse), 32'd0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 16'h0000);
    tick();
    chk("dns_pulse",  32'(err_pulse), 32'b000001);
    chk("dns_errcnt", 32'(err_count), 32'd1);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000);
    tick();
    clr_stats = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 16'h0000);
    tick();
    clr_stats = 1'b0;
    chk("clrerr_sticky", 32'(err_sticky), 32'b000001);
    chk("clrerr_errcnt", 32'(err_count),  32'd1);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000);
    tick();

    // Transaction counter saturation with CNT_W=4
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 3'd1, 8'(i), 8'h01, 1'b1, 16'h00AB);
      tick();
      drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000);
      tick();
      if (i == 14) chk("sat_txn_15", 32'(txn_count), 32'hF);
    end
    chk("sat_txn",     32'(txn_count),   32'hF);
    chk("sat_errcnt",  32'(err_count),   32'd0);
    chk("sat_lastres", 32'(last_result), 32'h00AB);

    // Async reset in the middle of a transaction
    drive(1'b1, 3'd2, 8'h09, 8'h09, 1'b0, 16'h0000);
    tick();
    chk("mr_busy", 32'(busy), 32'd1);
    drive(1'b1, 3'd2, 8'h08, 8'h09, 1'b0, 16'h0000);
    tick();
    chk("mr_oc_pulse",  32'(err_pulse),  32'b001000);
    chk("mr_oc_sticky", 32'(err_sticky), 32'b001000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_busy0",    32'(busy),        32'd0);
    chk("mr_pulse0",   32'(err_pulse),   32'd0);
    chk("mr_sticky0",  32'(err_sticky),  32'd0);
    chk("mr_errcnt0",  32'(err_count),   32'd0);
    chk("mr_txn0",     32'(txn_count),   32'd0);
    chk("mr_latmax0",  32'(lat_max),     32'd0);
    chk("mr_lastres0", 32'(last_result), 32'd0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000);
    #10;
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy",   32'(busy),      32'd0);
    chk("post_rst_pulse",  32'(err_pulse), 32'd0);
    chk("post_rst_errcnt", 32'(err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_protocol_checker.md
# alu_protocol_checker

Parametrised, synthesizable protocol checker for the start/done ALU handshake, replacing library-assertion monitoring with self-contained RTL. It adds NOP-aware checks, operand-stability and timeout checks, and per-rule sticky flags, plus latency and transaction statistics. It is bound passively alongside the ALU in simulation and on FPGA, drives nothing into the DUT, and its flags feed the scoreboard and an on-chip status register.

## Interface
Parameters:
- DATA_W, 8, operand width; result is 2*DATA_W
- OP_W, 3, opcode width
- NOP_OP, 0, opcode value that never produces done
- MAX_LAT, 8, cycles in BUSY without done before TIMEOUT fires (≥2)
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  1 = checks active; 0 = error detection masked, FSM and statistics still run
- clr_stats  in  1  synchronous clear of err_sticky, err_count, txn_count, lat_max
- start  in  1  DUT start
- op  in  OP_W  DUT opcode
- A, B  in  DATA_W  DUT operands
- done  in  1  DUT done
- result  in  2*DATA_W  DUT result
- err_pulse  out  6  per-rule one-cycle error strobe
- err_sticky  out  6  per-rule latched error
- err_count  out  CNT_W  saturating count of cycles with any error
- txn_count  out  CNT_W  saturating count of completed non-NOP transactions
- lat_max  out  $clog2(MAX_LAT+1)  largest completed latency
- last_result  out  2*DATA_W  result captured at last legal completion
- busy  out  1  FSM in BUSY

## Operation
- FSM states: IDLE, BUSY.
  - IDLE, start && op!=NOP_OP && !done → BUSY; capture op/A/B; lat←1.
  - IDLE, start && op!=NOP_OP && done → zero-latency completion; stay IDLE.
  - IDLE, start && op==NOP_OP → stay IDLE; set nop_d for the next cycle.
  - BUSY, done → completion; → IDLE.
  - BUSY, !done → lat←min(lat+1, MAX_LAT).
- Completion: txn_count++; lat_max←max(lat_max,lat); last_result←result.
- Rules (bit index):
  - [0] DONE_NO_START: done && !start.
  - [1] DONE_AFTER_NOP: done && nop_d.
  - [2] DONE_WIDTH: done && done_d.
  - [3] OPERAND_CHANGE: BUSY && start && {op,A,B} ≠ captured.
  - [4] TIMEOUT: BUSY && !done && lat==MAX_LAT; fires once per transaction.
  - [5] ABANDON: BUSY && !start && !done; → IDLE, no completion.
- Multiple rules may fire in one cycle; all corresponding bits are set; err_count increments by 1 per cycle.
- enable=0 forces err_pulse=0 and freezes err_sticky and err_count.
- clr_stats and a simultaneous new error: the new error wins for that bit/count (clear, then apply).
- Counters saturate at all-ones; no wrap.

## Timing
- Reset (async): state=IDLE; all outputs 0; nop_d, done_d, and captured registers 0.
- Detection in sample cycle N → err_pulse high in cycle N+1 only; err_sticky set from N+1.
- Latency = number of sample edges from start capture to done (start at edge 0, done at edge 3 → lat=3).
- Completion statistics update at edge N+1.
- Start held high in the cycle after done is treated as a new transaction from IDLE.
- Reset asserted mid-transaction abandons silently; no ABANDON flag.

## Structure
- Package alu_chk_pkg: state enum, rule index localparams (RULE_DONE_NO_START…RULE_ABANDON), NUM_RULES=6.
- Sub-module alu_chk_sat_counter (parameter W; inc, clr): instantiated for err_count and txn_count.

## Test plan
- Legal ADD: start, op=1, A=8'h05, B=8'h03, held; done at edge 3, result=16'h0008 → txn_count=1, lat_max=3, last_result=16'h0008, no errors.
- NOP then done: start with op=0 for one cycle, done next cycle → err_pulse[1] and err_pulse[0] together, err_count=1.
- done high 2 cycles on a legal op → err_pulse[2] on the second cycle only; txn_count=1.
- A changes 8'h05→8'h06 mid-BUSY → err_pulse[3]; MAX_LAT=8 with no done → err_pulse[4] once at lat=8, start then dropped → err_pulse[5], busy=0.
- enable=0 during a DONE_NO_START event → no pulse, no sticky; clr_stats coinciding with an error → sticky bit remains set, err_count=1.
- 2^CNT_W+2 legal transactions (CNT_W=4) → txn_count saturates at 4'hF; reset_n pulsed mid-BUSY → all outputs 0 immediately.
